// File: rtl/systolic_feed_pkg.sv
// Shared types and helpers for the systolic operand feeder.
// Build option: SYSTOLIC_FEED_SKEW_EN selects diagonal lane skew (L = D+S-1) instead of aligned lanes (L = D).
package systolic_feed_pkg;

  typedef logic [1:0] feed_state_t;

  localparam feed_state_t ST_IDLE   = 2'd0;
  localparam feed_state_t ST_STREAM = 2'd1;
  localparam feed_state_t ST_DONE   = 2'd2;

  typedef logic bank_idx_t;

  // Number of output beats per streamed bank.
  function automatic int stream_len(input int d, input int s);
`ifdef SYSTOLIC_FEED_SKEW_EN
    return (s < 1) ? 0 : d + s - 1;
`else
    return (s < 1) ? 0 : d;
`endif
  endfunction

endpackage

// File: rtl/systolic_operand_bank.sv
// One S x D x N operand bank: row-wide write port, per-lane element read port.
// An element index at or beyond D reads as zero, which provides the skew zero-fill.
module systolic_operand_bank #(
  parameter int N  = 2,
  parameter int S  = 4,
  parameter int D  = 4,
  parameter int IW = 4
) (
  input  logic                                 clk,
  input  logic                                 i_wr_en,
  input  logic [((S > 1) ? $clog2(S) : 1)-1:0] i_wr_row,
  input  logic [D*N-1:0]                       i_wr_data,
  input  logic [S*IW-1:0]                      i_rd_idx,
  output logic [S*N-1:0]                       o_rd_data
);

  logic [D*N-1:0] r_rows [S];
  logic [IW-1:0]  w_idx;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_rows[i_wr_row] <= i_wr_data;
    end
  end

  // Lane i always reads row i; only the element position varies per lane.
  always_comb begin
    o_rd_data = '0;
    w_idx     = '0;
    for (int i = 0; i < S; i++) begin
      w_idx = i_rd_idx[i*IW +: IW];
      if (w_idx < IW'(D)) begin
        o_rd_data[S*N-1-i*N -: N] = r_rows[i][D*N-1-int'(w_idx)*N -: N];
      end
    end
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Ping-pong operand feeder: loads rows into the free bank, streams the other bank column by column.
// Build option: SYSTOLIC_FEED_SKEW_EN enables per-row diagonal skew on the output lanes.
//
// state     | meaning
// ST_IDLE   | waiting for start with the read bank full
// ST_STREAM | emitting beats 0..L-1, one column per cycle
// ST_DONE   | done pulse; release the read bank unless hold was latched
module systolic_operand_feeder
  import systolic_feed_pkg::*;
#(
  parameter int N = 2,
  parameter int S = 4,
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_ld_valid,
  output logic           o_ld_ready,
  input  logic [D*N-1:0] i_ld_data,
  input  logic           i_start,
  input  logic           i_hold,
  output logic           o_busy,
  output logic           o_out_valid,
  output logic [S*N-1:0] o_out_data,
  output logic           o_done,
  output logic [1:0]     o_bank_full
);

  localparam int L  = stream_len(D, S);
  localparam int BW = $clog2(D + S);
  localparam int IW = BW + 1;
  localparam int RW = (S > 1) ? $clog2(S) : 1;

  localparam logic [BW-1:0] BEAT_END = BW'(L);
  localparam logic [RW-1:0] ROW_LAST = RW'(S - 1);

  logic [1:0]     r_full;
  bank_idx_t      r_wr_bank;
  bank_idx_t      r_rd_bank;
  logic [RW-1:0]  r_row_cnt;
  feed_state_t    r_state;
  logic           r_hold;
  logic [BW-1:0]  r_beat;
  logic           r_out_valid;
  logic [S*N-1:0] r_out_data;
  logic           r_done;

  logic           w_ld_fire;
  logic           w_row_last;
  logic [1:0]     w_full_set;
  logic [1:0]     w_full_clr;
  logic [1:0]     w_wr_en;
  logic [BW-1:0]  w_rd_t;
  logic [S*IW-1:0] w_rd_idx;
  logic [S*N-1:0] w_bank_rd [2];
  logic [S*N-1:0] w_col;

  assign o_ld_ready  = !r_full[r_wr_bank];
  assign o_bank_full = r_full;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_done      = r_done;

  assign w_ld_fire  = i_ld_valid && !r_full[r_wr_bank];
  assign w_row_last = (r_row_cnt == ROW_LAST);

  always_comb begin
    w_full_set = '0;
    w_full_clr = '0;
    w_wr_en    = '0;
    if (w_ld_fire) begin
      w_wr_en[r_wr_bank] = 1'b1;
      if (w_row_last) begin
        w_full_set[r_wr_bank] = 1'b1;
      end
    end
    if ((r_state == ST_DONE) && !r_hold) begin
      w_full_clr[r_rd_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_row_cnt <= '0;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
      if (w_ld_fire) begin
        if (w_row_last) begin
          r_row_cnt <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_row_cnt <= r_row_cnt + RW'(1);
        end
      end
    end
  end

  // r_beat holds the index of the next beat to present, so in IDLE the column for beat 0 is read.
  always_comb begin
    w_rd_t   = (r_state == ST_IDLE) ? '0 : r_beat;
    w_rd_idx = '0;
    for (int i = 0; i < S; i++) begin
`ifdef SYSTOLIC_FEED_SKEW_EN
      w_rd_idx[i*IW +: IW] = {1'b0, w_rd_t} - IW'(i);
`else
      w_rd_idx[i*IW +: IW] = {1'b0, w_rd_t};
`endif
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    systolic_operand_bank #(
      .N  (N),
      .S  (S),
      .D  (D),
      .IW (IW)
    ) u_bank (
      .clk       (clk),
      .i_wr_en   (w_wr_en[b]),
      .i_wr_row  (r_row_cnt),
      .i_wr_data (i_ld_data),
      .i_rd_idx  (w_rd_idx),
      .o_rd_data (w_bank_rd[b])
    );
  end

  assign w_col = w_bank_rd[r_rd_bank];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rd_bank   <= 1'b0;
      r_hold      <= 1'b0;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start && r_full[r_rd_bank]) begin
            r_state     <= ST_STREAM;
            r_hold      <= i_hold;
            r_out_valid <= 1'b1;
            r_out_data  <= w_col;
            r_beat      <= BW'(1);
          end else begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
          end
        end
        ST_STREAM: begin
          if (r_beat == BEAT_END) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b1;
          end else begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_col;
            r_beat      <= r_beat + BW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          if (!r_hold) begin
            r_rd_bank <= ~r_rd_bank;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Self-checking bench for systolic_operand_feeder against a queue-of-matrices reference model.
// Expected beat counts and lane contents follow SYSTOLIC_FEED_SKEW_EN when it is defined.
module tb_systolic_operand_feeder;

  localparam int TN = 2;
  localparam int TS = 4;
  localparam int TD = 4;
`ifdef SYSTOLIC_FEED_SKEW_EN
  localparam int L_EXP = TD + TS - 1;
`else
  localparam int L_EXP = TD;
`endif

  typedef logic [TS*TD*TN-1:0] mat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_ld_valid = 1'b0;
  logic              o_ld_ready;
  logic [TD*TN-1:0]  i_ld_data = '0;
  logic              i_start = 1'b0;
  logic              i_hold = 1'b0;
  logic              o_busy;
  logic              o_out_valid;
  logic [TS*TN-1:0]  o_out_data;
  logic              o_done;
  logic [1:0]        o_bank_full;

  int n_checks = 0;
  int n_errors = 0;

  mat_t mq[$];
  bit   m_rd = 1'b0;

  logic [TS*TN-1:0] cap_q[$];
  int               cap_beats;
  bit               cap_done_ok;
  int               cap_zero_viol;

  systolic_operand_feeder #(.N(TN), .S(TS), .D(TD)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ld_valid  (i_ld_valid),
    .o_ld_ready  (o_ld_ready),
    .i_ld_data   (i_ld_data),
    .i_start     (i_start),
    .i_hold      (i_hold),
    .o_busy      (o_busy),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .o_done      (o_done),
    .o_bank_full (o_bank_full)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat t of matrix m: lane i carries row i, element (t-i) with skew or element t without.
  function automatic logic [TS*TN-1:0] exp_beat(input mat_t m, input int t);
    logic [TS*TN-1:0] v;
    logic [TD*TN-1:0] row;
    int e;
    v = '0;
    for (int i = 0; i < TS; i++) begin
      row = m[TS*TD*TN-1-i*TD*TN -: TD*TN];
`ifdef SYSTOLIC_FEED_SKEW_EN
      e = t - i;
`else
      e = t;
`endif
      if (e >= 0 && e < TD) v[TS*TN-1-i*TN -: TN] = row[TD*TN-1-e*TN -: TN];
    end
    return v;
  endfunction

  function automatic logic [1:0] exp_full();
    if (mq.size() == 0) return 2'b00;
    if (mq.size() == 1) return m_rd ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int b = 0; b < TS*TD*TN; b++) m[b] = 1'($urandom_range(0, 1));
    return m;
  endfunction

  task automatic load_matrix(input mat_t m);
    bit got;
    for (int r = 0; r < TS; r++) begin
      i_ld_valid = 1'b1;
      i_ld_data  = m[TS*TD*TN-1-r*TD*TN -: TD*TN];
      got = 1'b0;
      for (int w = 0; w < 60 && !got; w++) begin
        got = o_ld_ready;
        tick();
      end
      if (!got) begin
        n_checks++;
        n_errors++;
        $display("FAIL load_accept row %0d: got ready=0 want 1 within 60 cycles", r);
      end
    end
    i_ld_valid = 1'b0;
    i_ld_data  = '0;
  endtask

  task automatic run_stream(input bit hold_v, input int poke_at);
    bit prev_valid;
    bit seen_done;
    cap_q.delete();
    cap_beats = 0;
    cap_done_ok = 1'b0;
    cap_zero_viol = 0;
    prev_valid = 1'b0;
    seen_done = 1'b0;
    i_start = 1'b1;
    i_hold  = hold_v;
    tick();
    i_start = 1'b0;
    i_hold  = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (o_out_valid) begin
        cap_q.push_back(o_out_data);
        cap_beats++;
      end else if (o_out_data != '0) begin
        cap_zero_viol++;
      end
      if (o_done) begin
        seen_done = 1'b1;
        cap_done_ok = prev_valid && !o_out_valid;
      end
      prev_valid = o_out_valid;
      i_start = (poke_at >= 0 && o_out_valid && cap_beats == poke_at + 1);
      tick();
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (o_ld_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ld_ready: got %0b want 1", o_ld_ready); end
    n_checks++; if (o_bank_full !== 2'b00) begin n_errors++; $display("FAIL reset_bank_full: got %0b want 00", o_bank_full); end
    n_checks++; if (o_out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0b want 0", o_out_valid); end
    n_checks++; if (o_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %0b want 0", o_done); end
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b want 0", o_busy); end
    n_checks++; if (o_out_data !== '0) begin n_errors++; $display("FAIL reset_out_data: got %0h want 0", o_out_data); end
  endtask

  task automatic test_single_stream();
    mat_t m;
    logic [TS*TN-1:0] want0;
    m = {8'hE4, 8'h1B, 8'hFF, 8'h00};
    load_matrix(m);
    mq.push_back(m);
    n_checks++; if (o_bank_full !== exp_full()) begin n_errors++; $display("FAIL single_full_after_load: got %0b want %0b", o_bank_full, exp_full()); end
    n_checks++; if (o_ld_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready_other_bank: got %0b want 1", o_ld_ready); end
    run_stream(1'b0, -1);
    n_checks++; if (cap_beats != L_EXP) begin n_errors++; $display("FAIL single_beats: got %0d want %0d", cap_beats, L_EXP); end
`ifdef SYSTOLIC_FEED_SKEW_EN
    want0 = 8'hC0;
`else
    want0 = 8'hCC;
`endif
    n_checks++; if (cap_q.size() < 1 || cap_q[0] !== want0) begin n_errors++; $display("FAIL single_beat0: got %0h want %0h", (cap_q.size() > 0) ? cap_q[0] : 8'hxx, want0); end
    for (int t = 0; t < cap_q.size(); t++) begin
      n_checks++; if (cap_q[t] !== exp_beat(m, t)) begin n_errors++; $display("FAIL single_beat%0d: got %0h want %0h", t, cap_q[t], exp_beat(m, t)); end
    end
    n_checks++; if (!cap_done_ok) begin n_errors++; $display("FAIL single_done_timing: got 0 want 1"); end
    n_checks++; if (cap_zero_viol != 0) begin n_errors++; $display("FAIL single_idle_data_zero: got %0d nonzero want 0", cap_zero_viol); end
    void'(mq.pop_front());
    m_rd = ~m_rd;
    n_checks++; if (o_bank_full !== 2'b00) begin n_errors++; $display("FAIL single_full_cleared: got %0b want 00", o_bank_full); end
    n_checks++; if (o_done !== 1'b0) begin n_errors++; $display("FAIL single_done_one_cycle: got %0b want 0", o_done); end
  endtask

  task automatic test_ping_pong();
    mat_t a, b;
    logic [1:0] pp_full;
    logic pp_rdy;
    a = rand_mat();
    b = rand_mat();
    load_matrix(a);
    mq.push_back(a);
    fork
      run_stream(1'b0, -1);
      begin
        load_matrix(b);
        pp_full = o_bank_full;
        pp_rdy  = o_ld_ready;
      end
    join
    mq.push_back(b);
    n_checks++; if (pp_full !== 2'b11) begin n_errors++; $display("FAIL pp_both_full: got %0b want 11", pp_full); end
    n_checks++; if (pp_rdy !== 1'b0) begin n_errors++; $display("FAIL pp_ready_blocked: got %0b want 0", pp_rdy); end
    n_checks++; if (cap_beats != L_EXP) begin n_errors++; $display("FAIL pp_first_beats: got %0d want %0d", cap_beats, L_EXP); end
    for (int t = 0; t < cap_q.size(); t++) begin
      n_checks++; if (cap_q[t] !== exp_beat(a, t)) begin n_errors++; $display("FAIL pp_first_beat%0d: got %0h want %0h", t, cap_q[t], exp_beat(a, t)); end
    end
    void'(mq.pop_front());
    m_rd = ~m_rd;
    n_checks++; if (o_ld_ready !== 1'b1) begin n_errors++; $display("FAIL pp_freed_ready: got %0b want 1", o_ld_ready); end
    n_checks++; if (o_bank_full !== exp_full()) begin n_errors++; $display("FAIL pp_full_after_first: got %0b want %0b", o_bank_full, exp_full()); end
    run_stream(1'b0, -1);
    n_checks++; if (cap_beats != L_EXP) begin n_errors++; $display("FAIL pp_second_beats: got %0d want %0d", cap_beats, L_EXP); end
    for (int t = 0; t < cap_q.size(); t++) begin
      n_checks++; if (cap_q[t] !== exp_beat(b, t)) begin n_errors++; $display("FAIL pp_second_beat%0d: got %0h want %0h", t, cap_q[t], exp_beat(b, t)); end
    end
    void'(mq.pop_front());
    m_rd = ~m_rd;
    n_checks++; if (o_bank_full !== 2'b00) begin n_errors++; $display("FAIL pp_full_end: got %0b want 00", o_bank_full); end
  endtask

  task automatic test_hold();
    mat_t c;
    logic [TS*TN-1:0] first_q[$];
    c = rand_mat();
    load_matrix(c);
    mq.push_back(c);
    run_stream(1'b1, -1);
    first_q = cap_q;
    n_checks++; if (o_bank_full !== exp_full()) begin n_errors++; $display("FAIL hold_full_kept: got %0b want %0b", o_bank_full, exp_full()); end
    run_stream(1'b1, -1);
    n_checks++; if (cap_beats != L_EXP || first_q.size() != L_EXP) begin n_errors++; $display("FAIL hold_beats: got %0d/%0d want %0d", first_q.size(), cap_beats, L_EXP); end
    for (int t = 0; t < cap_q.size() && t < first_q.size(); t++) begin
      n_checks++; if (cap_q[t] !== first_q[t] || cap_q[t] !== exp_beat(c, t)) begin n_errors++; $display("FAIL hold_beat%0d: got %0h/%0h want %0h", t, first_q[t], cap_q[t], exp_beat(c, t)); end
    end
    n_checks++; if (o_bank_full !== exp_full()) begin n_errors++; $display("FAIL hold_full_kept2: got %0b want %0b", o_bank_full, exp_full()); end
    run_stream(1'b0, -1);
    n_checks++; if (cap_q.size() < 1 || cap_q[0] !== exp_beat(c, 0)) begin n_errors++; $display("FAIL hold_release_data: want %0h", exp_beat(c, 0)); end
    void'(mq.pop_front());
    m_rd = ~m_rd;
    n_checks++; if (o_bank_full !== 2'b00) begin n_errors++; $display("FAIL hold_release_full: got %0b want 00", o_bank_full); end
  endtask

  task automatic test_illegal_start();
    mat_t d;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_checks++; if (o_busy !== 1'b0 || o_out_valid !== 1'b0) begin n_errors++; $display("FAIL illegal_empty_start: got busy=%0b valid=%0b want 0/0", o_busy, o_out_valid); end
    tick();
    n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_errors++; $display("FAIL illegal_empty_after: got busy=%0b done=%0b want 0/0", o_busy, o_done); end
    d = rand_mat();
    load_matrix(d);
    mq.push_back(d);
    run_stream(1'b0, 2);
    n_checks++; if (cap_beats != L_EXP) begin n_errors++; $display("FAIL illegal_restart_beats: got %0d want %0d", cap_beats, L_EXP); end
    n_checks++; if (!cap_done_ok) begin n_errors++; $display("FAIL illegal_restart_done: got 0 want 1"); end
    void'(mq.pop_front());
    m_rd = ~m_rd;
    tick();
    n_checks++; if (o_busy !== 1'b0 || o_bank_full !== 2'b00) begin n_errors++; $display("FAIL illegal_restart_idle: got busy=%0b full=%0b want 0/00", o_busy, o_bank_full); end
  endtask

  task automatic test_random();
    mat_t m;
    bit h;
    int bad;
    for (int it = 0; it < 8; it++) begin
      if (mq.size() == 0 || (mq.size() < 2 && $urandom_range(0, 1) == 1)) begin
        m = rand_mat();
        load_matrix(m);
        mq.push_back(m);
      end
      n_checks++; if (o_bank_full !== exp_full()) begin n_errors++; $display("FAIL rand%0d_full_pre: got %0b want %0b", it, o_bank_full, exp_full()); end
      h = 1'($urandom_range(0, 1));
      run_stream(h, -1);
      n_checks++; if (cap_beats != L_EXP) begin n_errors++; $display("FAIL rand%0d_beats: got %0d want %0d", it, cap_beats, L_EXP); end
      bad = 0;
      for (int t = 0; t < cap_q.size(); t++) if (cap_q[t] !== exp_beat(mq[0], t)) bad++;
      n_checks++; if (bad != 0) begin n_errors++; $display("FAIL rand%0d_data: got %0d wrong beats want 0", it, bad); end
      if (!h) begin
        void'(mq.pop_front());
        m_rd = ~m_rd;
      end
      n_checks++; if (o_bank_full !== exp_full()) begin n_errors++; $display("FAIL rand%0d_full_post: got %0b want %0b", it, o_bank_full, exp_full()); end
    end
  endtask

  task automatic test_reset_mid_stream();
    mat_t m;
    int cnt;
    bit found;
    int dones;
    m = rand_mat();
    if (mq.size() < 2) begin
      load_matrix(m);
      mq.push_back(m);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cnt = 0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (o_out_valid && cnt == 3) found = 1'b1;
      else begin
        if (o_out_valid) cnt++;
        tick();
      end
    end
    n_checks++; if (!found) begin n_errors++; $display("FAIL rstmid_reach_beat3: got %0d beats want 4", cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    m_rd = 1'b0;
    n_checks++; if (o_out_valid !== 1'b0 || o_busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_stop: got valid=%0b busy=%0b want 0/0", o_out_valid, o_busy); end
    n_checks++; if (o_bank_full !== 2'b00 || o_ld_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_flags: got full=%0b ready=%0b want 00/1", o_bank_full, o_ld_ready); end
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_done) dones++;
      tick();
    end
    n_checks++; if (dones != 0) begin n_errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dones); end
    m = rand_mat();
    load_matrix(m);
    mq.push_back(m);
    run_stream(1'b0, -1);
    n_checks++; if (cap_beats != L_EXP || cap_q.size() < 1 || cap_q[0] !== exp_beat(m, 0)) begin n_errors++; $display("FAIL rstmid_recover: got %0d beats want %0d with beat0 %0h", cap_beats, L_EXP, exp_beat(m, 0)); end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_ping_pong();
    test_hold();
    test_illegal_start();
    test_random();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
